// File: rtl/mem_responder.sv
// Byte-addressed memory target with a valid/ready request channel and a fixed-latency response.
// Loads and stores of byte/half/word size, little-endian, with misalignment and range errors.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_size,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int         LANES     = DATA_WIDTH / 8;
    localparam int         MEM_WORDS = 2 ** (ADDR_BITS - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    lat_we_q;
    logic [DATA_WIDTH-1:0]   lat_addr_q, lat_wdata_q;
    logic [2:0]              lat_size_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS] = '{default: '0};

    logic                    accept;
    logic                    do_access;
    logic                    acc_we;
    logic [DATA_WIDTH-1:0]   acc_addr, acc_wdata;
    logic [2:0]              acc_size;
    logic [ADDR_BITS-3:0]    word_idx;
    logic [DATA_WIDTH-1:0]   rd_word, rd_shifted, load_data, wr_data, acc_rdata;
    logic [LANES-1:0]        wr_mask;
    logic                    size_ok, misaligned, out_of_range, store_unsigned, acc_err, mem_we;

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    // With zero wait cycles the access happens on the accept edge, so it uses the live request.
    assign acc_we    = (state_q == S_IDLE) ? req_we    : lat_we_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : lat_addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : lat_wdata_q;
    assign acc_size  = (state_q == S_IDLE) ? req_size  : lat_size_q;

    assign word_idx   = acc_addr[ADDR_BITS-1:2];
    assign rd_word    = mem_q[word_idx];
    assign rd_shifted = rd_word >> {acc_addr[1:0], 3'b000};
    assign wr_data    = acc_wdata << {acc_addr[1:0], 3'b000};

    always_comb begin
        size_ok        = 1'b1;
        misaligned     = 1'b0;
        store_unsigned = 1'b0;
        load_data      = '0;
        wr_mask        = '0;
        unique case (acc_size)
            3'b000: begin
                load_data = {{(DATA_WIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]};
                wr_mask   = LANES'(1) << acc_addr[1:0];
            end
            3'b001: begin
                misaligned = acc_addr[0];
                load_data  = {{(DATA_WIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]};
                wr_mask    = LANES'(3) << {acc_addr[1], 1'b0};
            end
            3'b010: begin
                misaligned = (acc_addr[1:0] != 2'b00);
                load_data  = rd_word;
                wr_mask    = '1;
            end
            3'b100: begin
                store_unsigned = 1'b1;
                load_data      = {{(DATA_WIDTH-8){1'b0}}, rd_shifted[7:0]};
            end
            3'b101: begin
                store_unsigned = 1'b1;
                misaligned     = acc_addr[0];
                load_data      = {{(DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]};
            end
            default: size_ok = 1'b0;
        endcase
    end

    assign out_of_range = (acc_addr[DATA_WIDTH-1:ADDR_BITS] != '0);
    assign acc_err      = !size_ok || misaligned || out_of_range || (acc_we && store_unsigned);
    assign acc_rdata    = (acc_we || acc_err) ? '0 : load_data;
    assign do_access    = ((state_q == S_IDLE) && (WAIT_CYCLES == 0) && accept)
                       || ((state_q == S_WAIT) && (cnt_q == 4'd1));
    assign mem_we       = do_access && acc_we && !acc_err;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        rdata_d = acc_rdata;
                        err_d   = acc_err;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    rdata_d = acc_rdata;
                    err_d   = acc_err;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                lat_we_q    <= req_we;
                lat_addr_q  <= req_addr;
                lat_wdata_q <= req_wdata;
                lat_size_q  <= req_size;
            end
        end
    end

    // NOTE: memory is deliberately not reset; contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) mem_q[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected responses, a monitor pops and compares.
// A second instance built with zero wait cycles checks the minimum-latency path.
module tb_mem_responder;

    localparam int WAIT = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [2:0]  req_size;

    logic        req_valid0, req_ready0, req_we0, resp_valid0, resp_err0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic [2:0]  req_size0;

    int   tests  = 0;
    int   failed = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(10), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_size(req_size0),
        .resp_valid(resp_valid0), .resp_ready(1'b1),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor: every response handshake consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h err %b, expected no response",
                             resp_rdata, resp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check1("resp_err", resp_err, e.err);
                end
            end
        end
    end

    // Driver: issue one request, check latency and, with stall>0, output stability under backpressure.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input logic [31:0] exp_rd, input logic exp_err,
                          input int stall);
        int          n;
        logic [31:0] held;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        resp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("req_ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check1("req_ready_busy", req_ready, 1'b0);
        n = 1;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(WAIT + 1));
        held = resp_rdata;
        for (int k = 0; k < stall; k++) begin
            check1("stall_valid", resp_valid, 1'b1);
            check("stall_rdata", resp_rdata, held);
            check1("stall_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("after_hs_req_ready", req_ready, 1'b1);
        check1("after_hs_resp_valid", resp_valid, 1'b0);
    endtask

    task automatic do_req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, input logic [31:0] exp_rd);
        @(negedge clk);
        req_valid0 = 1'b1;
        req_we0    = we;
        req_addr0  = addr;
        req_wdata0 = wdata;
        req_size0  = size;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        check1("w0_resp_valid", resp_valid0, 1'b1);
        check("w0_rdata", resp_rdata0, exp_rd);
        check1("w0_err", resp_err0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check1("w0_req_ready", req_ready0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; req_size  = '0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_size0 = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check1("rst_req_ready", req_ready, 1'b0);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 32'h0);
        check1("rst_err", resp_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("post_rst_req_ready", req_ready, 1'b1);

        // Basic store/load and lane extraction.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 0);
        do_req(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 0);
        do_req(1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 0);
        do_req(1'b0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 1'b0, 0);
        do_req(1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 0);
        do_req(1'b1, 32'h11, 32'h00000055, 3'b000, 32'h0,        1'b0, 0);
        do_req(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 0);
        do_req(1'b0, 32'h10, 32'h0,        3'b101, 32'h000055EF, 1'b0, 0);

        // Error cases: misalignment, out of range, illegal size, unsigned store.
        do_req(1'b0, 32'h12, 32'h0,        3'b010, 32'h0,        1'b1, 0);
        do_req(1'b0, 32'h11, 32'h0,        3'b001, 32'h0,        1'b1, 0);
        do_req(1'b0, 32'h10, 32'h0,        3'b011, 32'h0,        1'b1, 0);
        do_req(1'b1, 32'h0,  32'h0BADF00D, 3'b010, 32'h0,        1'b0, 0);
        do_req(1'b1, 32'h400, 32'hAAAAAAAA, 3'b010, 32'h0,       1'b1, 0);
        do_req(1'b0, 32'h0,  32'h0,        3'b010, 32'h0BADF00D, 1'b0, 0);
        do_req(1'b1, 32'h10, 32'h000000FF, 3'b100, 32'h0,        1'b1, 0);
        do_req(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 0);

        // Top word in range, half store to upper lanes.
        do_req(1'b1, 32'h3FC, 32'h11223344, 3'b010, 32'h0,       1'b0, 0);
        do_req(1'b1, 32'h3FE, 32'h0000BEEF, 3'b001, 32'h0,       1'b0, 0);
        do_req(1'b0, 32'h3FC, 32'h0,        3'b010, 32'hBEEF3344, 1'b0, 0);

        // Backpressure in RESP.
        do_req(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 5);

        // Reset during WAIT aborts the store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_size  = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check1("abort_req_ready", req_ready, 1'b0);
        check1("abort_resp_valid", resp_valid, 1'b0);
        check("abort_rdata", resp_rdata, 32'h0);
        check1("abort_err", resp_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("abort_post_req_ready", req_ready, 1'b1);
        do_req(1'b0, 32'h20, 32'h0,        3'b010, 32'h0,        1'b0, 0);
        do_req(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 0);

        // Zero-wait instance.
        do_req0(1'b1, 32'h8, 32'hCAFEF00D, 3'b010, 32'h0);
        do_req0(1'b0, 32'h8, 32'h0,        3'b010, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
